// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: controller state encoding and register constants.
// The state enum is also consumed by anything decoding state_dbg.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_LOAD_WAIT = 3'd1,
        ST_RX_WAIT   = 3'd2,
        ST_TX_WAIT   = 3'd3,
        ST_FLUSH     = 3'd4
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         LAT_CNT_W = 3;

endpackage

// File: rtl/ex_pipe_ctrl_if.sv
// UART handshake bundle between the EX interlock controller and the UART block.
// Handshake: uart_rx_valid means the receive FIFO holds a byte and uart_tx_ready means
// the transmit side accepts a byte; the controller's single-cycle uart_rx_pop /
// uart_tx_push strobes are only ever raised in a cycle where the matching condition is 1.
interface ex_pipe_ctrl_if;
    logic uart_rx_valid;
    logic uart_tx_ready;
    logic uart_rx_pop;
    logic uart_tx_push;

    modport master (
        input  uart_rx_valid,
        input  uart_tx_ready,
        output uart_rx_pop,
        output uart_tx_push
    );

    modport slave (
        output uart_rx_valid,
        output uart_tx_ready,
        input  uart_rx_pop,
        input  uart_tx_push
    );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the
// instruction in ID. Kept separate so the forwarding unit can share it.
module hazard_detect
    import cpu_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic       ex_MemRead,
    input  logic       ex_RegWrite,
    input  logic [4:0] ex_rdist,
    output logic       load_use
);

    assign load_use = ex_valid & ex_MemRead & ex_RegWrite & (ex_rdist != REG_ZERO) &
                      id_valid & ((ex_rdist == id_rs) | (ex_rdist == id_rt));

endmodule

// File: rtl/ex_pipe_ctrl.sv
// Interlock controller around EX: load-use stalls, UART read/write sequencing and
// branch flushes resolved in MEM. Outputs are forced low while rst is asserted.
module ex_pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int LOAD_LATENCY   = 2,
    parameter int INST_MEM_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [4:0]                id_rs,
    input  logic [4:0]                id_rt,
    input  logic                      ex_valid,
    input  logic                      ex_RegWrite,
    input  logic                      ex_MemRead,
    input  logic                      ex_UARTtoReg,
    input  logic                      ex_RegtoUART,
    input  logic [4:0]                ex_rdist,
    input  logic                      mem_branch_taken,
    input  logic [INST_MEM_WIDTH-1:0] mem_branch_target,
    ex_pipe_ctrl_if.master            uart,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      hold_ex,
    output logic                      bubble_ex,
    output logic                      flush,
    output logic                      pc_load,
    output logic [INST_MEM_WIDTH-1:0] pc_target,
    output logic [2:0]                state_dbg
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LOAD_LATENCY - 1);

    ctrl_state_e          state, state_nxt;
    logic [LAT_CNT_W-1:0] wait_cnt, cnt_nxt;
    logic                 load_use;
    logic                 capture_target;
    logic                 stall_c, hold_c, bubble_c, flush_c, pc_load_c, pop_c, push_c;

    hazard_detect u_hazard (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_valid    (ex_valid),
        .ex_MemRead  (ex_MemRead),
        .ex_RegWrite (ex_RegWrite),
        .ex_rdist    (ex_rdist),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            pc_target <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
            if (capture_target) begin
                pc_target <= mem_branch_target;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = wait_cnt;
        capture_target = 1'b0;
        stall_c        = 1'b0;
        hold_c         = 1'b0;
        bubble_c       = 1'b0;
        flush_c        = 1'b0;
        pc_load_c      = 1'b0;
        pop_c          = 1'b0;
        push_c         = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_branch_taken) begin
                    flush_c        = 1'b1;
                    pc_load_c      = 1'b1;
                    capture_target = 1'b1;
                    state_nxt      = ST_FLUSH;
                end else if (ex_valid && ex_UARTtoReg) begin
                    if (uart.uart_rx_valid) begin
                        pop_c = 1'b1;
                    end else begin
                        stall_c   = 1'b1;
                        hold_c    = 1'b1;
                        state_nxt = ST_RX_WAIT;
                    end
                end else if (ex_valid && ex_RegtoUART) begin
                    if (uart.uart_tx_ready) begin
                        push_c = 1'b1;
                    end else begin
                        stall_c   = 1'b1;
                        hold_c    = 1'b1;
                        state_nxt = ST_TX_WAIT;
                    end
                end else if (load_use) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    // A single-cycle latency is fully covered by this RUN stall.
                    if (LOAD_LATENCY > 1) begin
                        state_nxt = ST_LOAD_WAIT;
                        cnt_nxt   = LAT_INIT;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                if (wait_cnt != '0) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    cnt_nxt  = wait_cnt - 1'b1;
                    if (wait_cnt == LAT_CNT_W'(1)) begin
                        state_nxt = ST_RUN;
                    end
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RX_WAIT: begin
                if (uart.uart_rx_valid) begin
                    pop_c     = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    stall_c = 1'b1;
                    hold_c  = 1'b1;
                end
            end
            ST_TX_WAIT: begin
                if (uart.uart_tx_ready) begin
                    push_c    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    stall_c = 1'b1;
                    hold_c  = 1'b1;
                end
            end
            ST_FLUSH: begin
                flush_c   = 1'b1;
                bubble_c  = 1'b1;
                pc_load_c = 1'b1;
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign stall_if          = stall_c & ~rst;
    assign stall_id          = stall_c & ~rst;
    assign hold_ex           = hold_c & ~rst;
    assign bubble_ex         = bubble_c & ~rst;
    assign flush             = flush_c & ~rst;
    assign pc_load           = pc_load_c & ~rst;
    assign uart.uart_rx_pop  = pop_c & ~rst;
    assign uart.uart_tx_push = push_c & ~rst;
    assign state_dbg         = state;

    // MEM is frozen during every wait state, so a taken branch there is a protocol error.
    a_no_branch_in_wait: assert property (@(posedge clk) disable iff (rst)
        ((state == ST_LOAD_WAIT) || (state == ST_RX_WAIT) || (state == ST_TX_WAIT))
        |-> !mem_branch_taken);

    a_hold_bubble_excl: assert property (@(posedge clk) disable iff (rst)
        !(hold_ex && bubble_ex) && (stall_if == stall_id));

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Bench for ex_pipe_ctrl: directed scenarios plus random traffic, checked cycle by
// cycle against a behavioural model of the interlock rules through an expected queue.
module tb_ex_pipe_ctrl;

    localparam int LAT        = 2;
    localparam int W          = 13;
    localparam int N_RANDOM   = 600;

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       ex_valid;
        logic       ex_RegWrite;
        logic       ex_MemRead;
        logic       ex_UARTtoReg;
        logic       ex_RegtoUART;
        logic [4:0] ex_rdist;
        logic       br;
        logic [1:0] tgt;
        logic       rx_valid;
        logic       tx_ready;
    } stim_t;

    // clock / reset and DUT signals
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       ex_valid = 1'b0;
    logic       ex_RegWrite = 1'b0;
    logic       ex_MemRead = 1'b0;
    logic       ex_UARTtoReg = 1'b0;
    logic       ex_RegtoUART = 1'b0;
    logic [4:0] ex_rdist = '0;
    logic       mem_branch_taken = 1'b0;
    logic [1:0] mem_branch_target = '0;
    logic       stall_if, stall_id, hold_ex, bubble_ex, flush, pc_load;
    logic [1:0] pc_target;
    logic [2:0] state_dbg;

    ex_pipe_ctrl_if uart_bus ();

    ex_pipe_ctrl #(.LOAD_LATENCY(LAT), .INST_MEM_WIDTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_valid          (id_valid),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .ex_valid          (ex_valid),
        .ex_RegWrite       (ex_RegWrite),
        .ex_MemRead        (ex_MemRead),
        .ex_UARTtoReg      (ex_UARTtoReg),
        .ex_RegtoUART      (ex_RegtoUART),
        .ex_rdist          (ex_rdist),
        .mem_branch_taken  (mem_branch_taken),
        .mem_branch_target (mem_branch_target),
        .uart              (uart_bus),
        .stall_if          (stall_if),
        .stall_id          (stall_id),
        .hold_ex           (hold_ex),
        .bubble_ex         (bubble_ex),
        .flush             (flush),
        .pc_load           (pc_load),
        .pc_target         (pc_target),
        .state_dbg         (state_dbg)
    );

    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // reference model: what the pipeline is currently waiting on
    int         load_left  = 0;     // further load stall cycles still owed
    bit         wait_rx    = 1'b0;  // held UART read awaiting a byte
    bit         wait_tx    = 1'b0;  // held UART write awaiting space
    bit         flush_next = 1'b0;  // this cycle is the post-branch flush cycle
    logic [1:0] target     = '0;

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic bit model_busy();
        return (load_left > 0) || wait_rx || wait_tx;
    endfunction

    task automatic step(input stim_t s_in);
        stim_t s;
        logic  o_stall, o_hold, o_bubble, o_flush, o_pcl, o_pop, o_push;
        logic [2:0] o_state;
        bit    hazard;
        s = s_in;
        if (model_busy()) s.br = 1'b0;
        @(posedge clk);
        #1;
        rst               = s.rst;
        id_valid          = s.id_valid;
        id_rs             = s.id_rs;
        id_rt             = s.id_rt;
        ex_valid          = s.ex_valid;
        ex_RegWrite       = s.ex_RegWrite;
        ex_MemRead        = s.ex_MemRead;
        ex_UARTtoReg      = s.ex_UARTtoReg;
        ex_RegtoUART      = s.ex_RegtoUART;
        ex_rdist          = s.ex_rdist;
        mem_branch_taken  = s.br;
        mem_branch_target = s.tgt;
        uart_bus.uart_rx_valid = s.rx_valid;
        uart_bus.uart_tx_ready = s.tx_ready;

        {o_stall, o_hold, o_bubble, o_flush, o_pcl, o_pop, o_push} = '0;
        o_state = 3'd0;
        hazard  = s.ex_valid && s.ex_MemRead && s.ex_RegWrite && (s.ex_rdist != 0) &&
                  s.id_valid && ((s.ex_rdist == s.id_rs) || (s.ex_rdist == s.id_rt));

        if (s.rst) begin
            load_left = 0; wait_rx = 0; wait_tx = 0; flush_next = 0; target = '0;
            exp_q.push_back('0);
        end else begin
            if (flush_next) begin
                o_flush = 1; o_bubble = 1; o_pcl = 1; o_state = 3'd4;
                flush_next = 0;
            end else if (load_left > 0) begin
                o_stall = 1; o_bubble = 1; o_state = 3'd1;
                load_left--;
            end else if (wait_rx) begin
                o_state = 3'd2;
                if (s.rx_valid) begin o_pop = 1; wait_rx = 0; end
                else begin o_stall = 1; o_hold = 1; end
            end else if (wait_tx) begin
                o_state = 3'd3;
                if (s.tx_ready) begin o_push = 1; wait_tx = 0; end
                else begin o_stall = 1; o_hold = 1; end
            end else if (s.br) begin
                o_flush = 1; o_pcl = 1; flush_next = 1;
            end else if (s.ex_valid && s.ex_UARTtoReg) begin
                if (s.rx_valid) o_pop = 1;
                else begin o_stall = 1; o_hold = 1; wait_rx = 1; end
            end else if (s.ex_valid && s.ex_RegtoUART) begin
                if (s.tx_ready) o_push = 1;
                else begin o_stall = 1; o_hold = 1; wait_tx = 1; end
            end else if (hazard) begin
                o_stall = 1; o_bubble = 1; load_left = LAT - 1;
            end
            exp_q.push_back({o_stall, o_stall, o_hold, o_bubble, o_flush, o_pcl, target,
                             o_pop, o_push, o_state});
            if (s.br && !o_flush_from_wait(o_state)) target = s.tgt;
        end
    endtask

    // The target only latches on a branch seen while running freely.
    function automatic bit o_flush_from_wait(input logic [2:0] st);
        return st != 3'd0;
    endfunction

    // monitor
    always @(negedge clk) begin
        logic [W-1:0] got, exp;
        cyc++;
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            got = {stall_if, stall_id, hold_ex, bubble_ex, flush, pc_load, pc_target,
                   uart_bus.uart_rx_pop, uart_bus.uart_tx_push, state_dbg};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL outputs cycle %0d: got %b required %b (sif sid hold bub fl pcl tgt pop push st)",
                         cyc, got, exp);
            end
        end
    end

    // stimulus
    initial begin
        stim_t s;
        uart_bus.uart_rx_valid = 1'b0;
        uart_bus.uart_tx_ready = 1'b0;

        s = idle_stim(); s.rst = 1;
        repeat (2) step(s);
        step(idle_stim());

        // load-use on r5, then the same pair with rdist=0
        s = idle_stim();
        s.ex_valid = 1; s.ex_RegWrite = 1; s.ex_MemRead = 1; s.ex_rdist = 5;
        s.id_valid = 1; s.id_rs = 5; s.id_rt = 1;
        step(s);
        repeat (3) step(idle_stim());
        s.ex_rdist = 0; s.id_rs = 0;
        step(s);
        step(idle_stim());

        // UART read with rx empty for 3 cycles
        s = idle_stim();
        s.ex_valid = 1; s.ex_UARTtoReg = 1;
        repeat (3) step(s);
        s.rx_valid = 1;
        step(s);
        step(idle_stim());

        // UART write, tx ready at once
        s = idle_stim();
        s.ex_valid = 1; s.ex_RegtoUART = 1; s.tx_ready = 1;
        step(s);
        step(idle_stim());

        // branch together with load-use
        s = idle_stim();
        s.ex_valid = 1; s.ex_RegWrite = 1; s.ex_MemRead = 1; s.ex_rdist = 7;
        s.id_valid = 1; s.id_rt = 7; s.br = 1; s.tgt = 2'b10;
        step(s);
        s.br = 0;
        step(s);
        repeat (2) step(idle_stim());

        // reset on the second cycle of a TX wait
        s = idle_stim();
        s.ex_valid = 1; s.ex_RegtoUART = 1;
        repeat (2) step(s);
        s.rst = 1;
        step(s);
        s = idle_stim(); s.tx_ready = 1;
        repeat (2) step(s);

        // UART read and load-use together with rx empty
        s = idle_stim();
        s.ex_valid = 1; s.ex_UARTtoReg = 1; s.ex_RegWrite = 1; s.ex_MemRead = 1;
        s.ex_rdist = 3; s.id_valid = 1; s.id_rs = 3;
        step(s);
        s.rx_valid = 1;
        step(s);
        s.ex_UARTtoReg = 0; s.rx_valid = 0;
        step(s);
        repeat (3) step(idle_stim());

        // random traffic
        for (int i = 0; i < N_RANDOM; i++) begin
            s = idle_stim();
            s.rst          = ($urandom_range(0, 63) == 0);
            s.id_valid     = ($urandom_range(0, 3) != 0);
            s.id_rs        = 5'($urandom_range(0, 3));
            s.id_rt        = 5'($urandom_range(0, 3));
            s.ex_valid     = ($urandom_range(0, 3) != 0);
            s.ex_RegWrite  = ($urandom_range(0, 2) != 0);
            s.ex_MemRead   = ($urandom_range(0, 1) != 0);
            s.ex_UARTtoReg = ($urandom_range(0, 5) == 0);
            s.ex_RegtoUART = ($urandom_range(0, 5) == 0);
            s.ex_rdist     = 5'($urandom_range(0, 3));
            s.br           = ($urandom_range(0, 7) == 0);
            s.tgt          = 2'($urandom_range(0, 3));
            s.rx_valid     = ($urandom_range(0, 1) != 0);
            s.tx_ready     = ($urandom_range(0, 1) != 0);
            step(s);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ex_pipe_ctrl.md
Name: ex_pipe_ctrl

Overview:
- Central interlock controller for the 5-stage pipeline around the execution stage.
- Decides each cycle whether IF/ID advance, whether EX receives a bubble or holds, and whether IF/ID are flushed.
- Detects load-use hazards against the instruction in EX.
- Sequences the UART handshake for UARTtoReg/RegtoUART instructions, holding EX until the UART side is ready.
- Applies branch flushes resolved in MEM.

Parameters:
- LOAD_LATENCY, 2: cycles from MemRead in EX until load data is forwardable; allowed range 1..7.
- INST_MEM_WIDTH, 2: PC width; used only for the flush target passthrough.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs  in  5  ID source register 1
- id_rt  in  5  ID source register 2
- ex_valid  in  1  valid instruction in EX
- ex_RegWrite  in  1  EX instruction writes a register
- ex_MemRead  in  1  EX instruction is a load
- ex_UARTtoReg  in  1  EX instruction reads UART
- ex_RegtoUART  in  1  EX instruction writes UART
- ex_rdist  in  5  EX destination register
- mem_branch_taken  in  1  branch taken, resolved in MEM
- mem_branch_target  in  INST_MEM_WIDTH  target PC
- uart_rx_valid  in  1  receive FIFO non-empty
- uart_tx_ready  in  1  transmit side can accept a byte
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- hold_ex  out  1  hold ID/EX register contents (EX re-executes)
- bubble_ex  out  1  load NOP into ID/EX
- flush  out  1  invalidate IF/ID and ID/EX
- pc_load  out  1  load PC from pc_target
- pc_target  out  INST_MEM_WIDTH  registered copy of mem_branch_target
- uart_rx_pop  out  1  one-cycle pop strobe
- uart_tx_push  out  1  one-cycle push strobe
- state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, rst=1): state=RUN, wait counter=0, pc_target=0. All outputs 0; state_dbg=RUN.
- States:
  - RUN=0
  - LOAD_WAIT=1
  - RX_WAIT=2
  - TX_WAIT=3
  - FLUSH=4
  - Encodings 5..7 are unreachable and return to RUN.
- Hazard term load_use = ex_valid & ex_MemRead & ex_RegWrite & ex_rdist!=0 & id_valid & (ex_rdist==id_rs | ex_rdist==id_rt).
- RUN priority, highest first:
  1. mem_branch_taken → FLUSH. Same cycle: flush=1, pc_load=1; pc_target registered at the clock edge.
  2. ex_valid & ex_UARTtoReg:
     - uart_rx_valid=1 → uart_rx_pop=1 this cycle, stay in RUN.
     - Else → RX_WAIT with stall_if=stall_id=hold_ex=1.
  3. ex_valid & ex_RegtoUART:
     - uart_tx_ready=1 → uart_tx_push=1, stay in RUN.
     - Else → TX_WAIT with holds asserted.
  4. load_use → LOAD_WAIT, counter=LOAD_LATENCY-1. Same cycle: stall_if=stall_id=1, bubble_ex=1.
  5. Otherwise all outputs 0.
- LOAD_WAIT:
  - stall_if=stall_id=bubble_ex=1 while counter≠0; counter decrements each cycle; counter=0 → RUN.
  - Total stall cycles = LOAD_LATENCY.
  - For LOAD_LATENCY=1, LOAD_WAIT is skipped: one stall cycle in RUN, then back to RUN.
- RX_WAIT:
  - stall_if=stall_id=hold_ex=1 until uart_rx_valid=1.
  - On that cycle: uart_rx_pop=1, holds deasserted, next state RUN.
- TX_WAIT: same as RX_WAIT, using uart_tx_ready and uart_tx_push.
- FLUSH:
  - Lasts exactly one cycle: flush=1, bubble_ex=1, pc_load=1 with pc_target valid.
  - Next state RUN. Hazards are not evaluated in this cycle.
- Simultaneous events:
  - Branch beats UART and load-use.
  - UART beats load-use.
  - mem_branch_taken during any WAIT state is ignored; MEM is frozen, so this is a protocol error that assertions must flag.
- Pop and push are each at most one pulse per EX instruction, never in consecutive cycles for the same instruction.
- rst asserted mid-wait: immediate return to RUN, all strobes 0, no pop/push emitted.
- stall_if==stall_id always. hold_ex and bubble_ex are never both 1.

Decomposition:
- Shared package (cpu_pkg):
  - state typedef (enum logic [2:0]) used by state_dbg consumers.
  - Register-zero constant REG_ZERO=5'd0.
- Sub-module hazard_detect: combinational load_use term, reusable by the forwarding unit.
- FSM and counter stay in ex_pipe_ctrl.

Test Plan:
- Load-use, LOAD_LATENCY=2: ex lw r5, id add r6,r5,r1 → stall_if/stall_id/bubble_ex=1 for exactly 2 cycles, then all 0. Same instruction with rdist=0 → no stall.
- UART read, rx empty: ex_UARTtoReg=1, uart_rx_valid=0 for 3 cycles, then 1 → hold_ex=1 for 3 cycles, uart_rx_pop=1 on the 4th cycle only, state back to RUN.
- UART write, tx ready immediately: uart_tx_push=1 same cycle, no stall.
- Branch with load-use same cycle: mem_branch_taken=1, target=2'b10, load_use=1 → flush=1 and pc_load=1 this cycle and next, pc_target=2, no LOAD_WAIT entered.
- rst pulse during TX_WAIT (cycle 2 of wait) → outputs 0 asynchronously, state_dbg=0, no push afterward even when uart_tx_ready rises.
- UARTtoReg and load_use together with rx empty → RX_WAIT taken; after the pop, the load-use stall still occurs when re-evaluated in RUN.
